// File: rtl/alu_result_serializer.sv
// Captures an ALU result plus status flags and streams it out as an 8-bit
// framed byte stream, with a one-entry pending buffer behind the active frame.
module alu_result_serializer #(
  parameter int DATA_W      = 32,
  parameter bit MSB_FIRST   = 1'b0,
  parameter bit INCLUDE_HDR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_valid,
  output logic              cap_ready,
  input  logic [DATA_W-1:0] cap_result,
  input  logic [3:0]        cap_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              busy,
  output logic [3:0]        seq
);

  localparam int NB = DATA_W / 8;
  localparam logic [2:0] LAST_IDX = 3'(NB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_FIRST = INCLUDE_HDR ? S_HDR : S_DATA;

  logic [1:0]        r_state;
  logic [2:0]        r_idx;
  logic [DATA_W-1:0] r_act_result;
  logic [3:0]        r_act_flags;
  logic [3:0]        r_act_seq;
  logic              r_pnd_valid;
  logic [DATA_W-1:0] r_pnd_result;
  logic [3:0]        r_pnd_flags;
  logic [3:0]        r_pnd_seq;
  logic [3:0]        r_seq_cnt;
  logic [7:0]        r_out_data;
  logic              r_out_last;

  logic              w_cap;
  logic              w_xfer;
  logic              w_done;
  logic [1:0]        w_nxt_state;
  logic [2:0]        w_nxt_idx;
  logic [DATA_W-1:0] w_nxt_result;
  logic [3:0]        w_nxt_flags;
  logic [3:0]        w_nxt_seq;
  logic              w_nxt_pnd_valid;
  logic [DATA_W-1:0] w_nxt_pnd_result;
  logic [3:0]        w_nxt_pnd_flags;
  logic [3:0]        w_nxt_pnd_seq;
  logic [2:0]        w_sel_idx;
  logic [7:0]        w_data_byte;
  logic [7:0]        w_nxt_byte;
  logic              w_nxt_last;

  assign w_cap  = cap_valid && !r_pnd_valid;
  assign w_xfer = (r_state != S_IDLE) && out_ready;
  assign w_done = w_xfer && r_out_last;

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_idx        = r_idx;
    w_nxt_result     = r_act_result;
    w_nxt_flags      = r_act_flags;
    w_nxt_seq        = r_act_seq;
    w_nxt_pnd_valid  = r_pnd_valid;
    w_nxt_pnd_result = r_pnd_result;
    w_nxt_pnd_flags  = r_pnd_flags;
    w_nxt_pnd_seq    = r_pnd_seq;
    if (r_state == S_IDLE) begin
      if (w_cap) begin
        w_nxt_state  = S_FIRST;
        w_nxt_idx    = '0;
        w_nxt_result = cap_result;
        w_nxt_flags  = cap_flags;
        w_nxt_seq    = r_seq_cnt;
      end
    end else if (w_done) begin
      // Pending frame takes priority; a capture can only land here if pending is empty.
      if (r_pnd_valid) begin
        w_nxt_state     = S_FIRST;
        w_nxt_idx       = '0;
        w_nxt_result    = r_pnd_result;
        w_nxt_flags     = r_pnd_flags;
        w_nxt_seq       = r_pnd_seq;
        w_nxt_pnd_valid = 1'b0;
      end else if (w_cap) begin
        w_nxt_state  = S_FIRST;
        w_nxt_idx    = '0;
        w_nxt_result = cap_result;
        w_nxt_flags  = cap_flags;
        w_nxt_seq    = r_seq_cnt;
      end else begin
        w_nxt_state = S_IDLE;
        w_nxt_idx   = '0;
      end
    end else begin
      if (w_xfer) begin
        if (r_state == S_HDR) begin
          w_nxt_state = S_DATA;
          w_nxt_idx   = '0;
        end else begin
          w_nxt_idx = r_idx + 3'd1;
        end
      end
      if (w_cap) begin
        w_nxt_pnd_valid  = 1'b1;
        w_nxt_pnd_result = cap_result;
        w_nxt_pnd_flags  = cap_flags;
        w_nxt_pnd_seq    = r_seq_cnt;
      end
    end
  end

  // Byte for the next cycle is selected from the next-state view so out_data is registered.
  assign w_sel_idx = MSB_FIRST ? (LAST_IDX - w_nxt_idx) : w_nxt_idx;

  always_comb begin
    w_data_byte = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      if (w_sel_idx == 3'(k)) begin
        w_data_byte = w_nxt_result[8*k +: 8];
      end
    end
  end

  always_comb begin
    w_nxt_byte = '0;
    w_nxt_last = 1'b0;
    if (w_nxt_state == S_HDR) begin
      w_nxt_byte = {w_nxt_flags, w_nxt_seq};
    end else if (w_nxt_state == S_DATA) begin
      w_nxt_byte = w_data_byte;
      w_nxt_last = (w_nxt_idx == LAST_IDX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_act_result <= '0;
      r_act_flags  <= '0;
      r_act_seq    <= '0;
      r_pnd_valid  <= 1'b0;
      r_pnd_result <= '0;
      r_pnd_flags  <= '0;
      r_pnd_seq    <= '0;
      r_seq_cnt    <= '0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_idx        <= w_nxt_idx;
      r_act_result <= w_nxt_result;
      r_act_flags  <= w_nxt_flags;
      r_act_seq    <= w_nxt_seq;
      r_pnd_valid  <= w_nxt_pnd_valid;
      r_pnd_result <= w_nxt_pnd_result;
      r_pnd_flags  <= w_nxt_pnd_flags;
      r_pnd_seq    <= w_nxt_pnd_seq;
      if (w_cap) begin
        r_seq_cnt <= r_seq_cnt + 4'd1;
      end
      r_out_data   <= w_nxt_byte;
      r_out_last   <= w_nxt_last;
    end
  end

  assign cap_ready = !r_pnd_valid;
  assign out_valid = (r_state != S_IDLE);
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state != S_IDLE) || r_pnd_valid;
  assign seq       = r_act_seq;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Randomised and directed bench for alu_result_serializer against a frame-queue
// reference model; a second instance covers MSB-first, headerless framing.
module tb_alu_result_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cap_valid = 1'b0, cap_ready;
  logic [31:0] cap_result = '0;
  logic [3:0]  cap_flags = '0;
  logic        out_valid, out_ready = 1'b0, out_last, busy;
  logic [7:0]  out_data;
  logic [3:0]  seq;

  logic        b_cap_valid = 1'b0, b_cap_ready;
  logic [31:0] b_cap_result = '0;
  logic [3:0]  b_cap_flags = '0;
  logic        b_out_valid, b_out_ready = 1'b0, b_out_last, b_busy;
  logic [7:0]  b_out_data;
  logic [3:0]  b_seq;

  alu_result_serializer #(.DATA_W(32), .MSB_FIRST(1'b0), .INCLUDE_HDR(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid), .cap_ready(cap_ready),
    .cap_result(cap_result), .cap_flags(cap_flags), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .seq(seq)
  );

  alu_result_serializer #(.DATA_W(32), .MSB_FIRST(1'b1), .INCLUDE_HDR(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cap_valid(b_cap_valid), .cap_ready(b_cap_ready),
    .cap_result(b_cap_result), .cap_flags(b_cap_flags), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .busy(b_busy), .seq(b_seq)
  );

  typedef struct packed {
    logic       last;
    logic [3:0] tag;
    logic [7:0] b;
  } ent_t;

  ent_t       q[$];
  int         nfr;
  logic [3:0] tag_cnt;
  logic [7:0] log_b[$];
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Header {flags, tag} followed by result bytes least-significant first.
  task automatic push_frame(input logic [31:0] res, input logic [3:0] fl, input logic [3:0] tg);
    q.push_back({1'b0, tg, fl, tg});
    for (int k = 0; k < 4; k++) q.push_back({(k == 3), tg, 8'(res >> (8 * k))});
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst_n = 1'b0;
    cap_valid = 1'b0;
    out_ready = 1'b0;
    q.delete();
    log_b.delete();
    nfr = 0;
    tag_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge: check outputs, drive inputs, advance model across the next posedge.
  task automatic step(input logic cv, input logic [31:0] res, input logic [3:0] fl,
                      input logic ordy, output logic acc);
    ent_t e;
    logic cap_ok;
    check_eq("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      e = q[0];
      check_eq("out_data", 32'(out_data), 32'(e.b));
      check_eq("out_last", 32'(out_last), 32'(e.last));
      check_eq("seq", 32'(seq), 32'(e.tag));
    end else begin
      check_eq("idle_data", 32'(out_data), 32'h0);
      check_eq("idle_last", 32'(out_last), 32'h0);
    end
    check_eq("cap_ready", 32'(cap_ready), 32'(nfr < 2));
    check_eq("busy", 32'(busy), 32'(nfr > 0));
    cap_valid = cv;
    cap_result = res;
    cap_flags = fl;
    out_ready = ordy;
    cap_ok = cv && (nfr < 2);
    if (out_valid && ordy) log_b.push_back(out_data);
    if ((q.size() > 0) && ordy) begin
      e = q.pop_front();
      if (e.last) nfr--;
    end
    if (cap_ok) begin
      push_frame(res, fl, tag_cnt);
      tag_cnt = tag_cnt + 4'd1;
      nfr++;
    end
    acc = cap_ok;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_log(input string tag, input logic [7:0] exp[$]);
    check_eq({tag, "_len"}, 32'(log_b.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < log_b.size(); i++)
      check_eq(tag, 32'(log_b[i]), 32'(exp[i]));
  endtask

  initial begin
    logic acc;
    logic pv;
    logic [31:0] pr;
    logic [3:0] pf;
    logic [3:0] fls[17];
    int waited;

    // Reset values
    @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'h0);
    check_eq("rst_data", 32'(out_data), 32'h0);
    check_eq("rst_last", 32'(out_last), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_seq", 32'(seq), 32'h0);
    check_eq("rst_ready", 32'(cap_ready), 32'h1);

    // Single frame
    reset_all();
    step(1'b1, 32'hDEADBEEF, 4'b1000, 1'b1, acc);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1, acc);
    check_log("single", '{8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE});

    // Back-pressure while 0xBE is presented
    reset_all();
    step(1'b1, 32'hDEADBEEF, 4'b1000, 1'b1, acc);
    step(1'b0, '0, '0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b1, acc);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, acc);
    check_eq("bp_hold_data", 32'(out_data), 32'hBE);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, acc);
    check_log("bp", '{8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE});

    // Back-to-back captures with a third held until accepted
    reset_all();
    step(1'b1, 32'h11223344, 4'h3, 1'b1, acc);
    step(1'b1, 32'h55667788, 4'h5, 1'b1, acc);
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 40) begin
      step(1'b1, 32'h99AABBCC, 4'h7, 1'b1, acc);
      waited++;
    end
    check_eq("b2b_third_accept_cycle", 32'(waited), 32'd5);
    for (int i = 0; i < 12; i++) step(1'b0, '0, '0, 1'b1, acc);
    check_log("b2b", '{8'h30, 8'h44, 8'h33, 8'h22, 8'h11, 8'h51, 8'h88, 8'h77, 8'h66, 8'h55,
                       8'h72, 8'hCC, 8'hBB, 8'hAA, 8'h99});

    // Capture in the same cycle as the last byte, pending empty
    reset_all();
    step(1'b1, 32'hDEADBEEF, 4'b1000, 1'b1, acc);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, acc);
    step(1'b1, 32'h01020304, 4'b0001, 1'b1, acc);
    check_eq("same_cycle_accept", 32'(acc), 32'h1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1, acc);
    check_log("same_cycle", '{8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h11, 8'h04, 8'h03, 8'h02, 8'h01});

    // Sequence wrap over 17 frames
    reset_all();
    for (int f = 0; f < 17; f++) begin
      fls[f] = 4'($urandom_range(0, 15));
      step(1'b1, $urandom, fls[f], 1'b1, acc);
      for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1, acc);
    end
    check_eq("wrap_len", 32'(log_b.size()), 32'd85);
    for (int f = 0; f < 17 && (5 * f) < log_b.size(); f++)
      check_eq("wrap_hdr", 32'(log_b[5 * f]), 32'({fls[f], 4'(f % 16)}));

    // Randomised traffic with a holding producer
    reset_all();
    pv = 1'b0;
    pr = '0;
    pf = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pv && $urandom_range(0, 2) == 0) begin
        pv = 1'b1;
        pr = $urandom;
        pf = 4'($urandom_range(0, 15));
      end
      step(pv, pr, pf, ($urandom_range(0, 3) != 0), acc);
      if (acc) pv = 1'b0;
    end
    for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b1, acc);
    check_eq("rand_drained", 32'(q.size()), 32'h0);

    // MSB-first, headerless instance with mid-frame reset
    reset_all();
    b_out_ready = 1'b1;
    b_cap_valid = 1'b1;
    b_cap_result = 32'hDEADBEEF;
    b_cap_flags = 4'hA;
    @(posedge clk);
    @(negedge clk);
    b_cap_valid = 1'b0;
    check_eq("b_byte0", 32'({b_out_valid, b_out_last, b_out_data}), 32'h2DE);
    @(negedge clk);
    check_eq("b_byte1", 32'({b_out_valid, b_out_last, b_out_data}), 32'h2AD);
    @(negedge clk);
    check_eq("b_byte2", 32'({b_out_valid, b_out_last, b_out_data}), 32'h2BE);
    rst_n = 1'b0;
    #1;
    check_eq("b_rst_valid", 32'(b_out_valid), 32'h0);
    check_eq("b_rst_ready", 32'(b_cap_ready), 32'h1);
    check_eq("b_rst_seq", 32'(b_seq), 32'h0);
    check_eq("b_rst_data", 32'(b_out_data), 32'h0);
    check_eq("b_rst_busy", 32'(b_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    b_cap_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_cap_valid = 1'b0;
    check_eq("b_re_byte0", 32'({b_out_valid, b_out_last, b_out_data}), 32'h2DE);
    @(negedge clk);
    check_eq("b_re_byte1", 32'({b_out_valid, b_out_last, b_out_data}), 32'h2AD);
    @(negedge clk);
    check_eq("b_re_byte2", 32'({b_out_valid, b_out_last, b_out_data}), 32'h2BE);
    @(negedge clk);
    check_eq("b_re_byte3", 32'({b_out_valid, b_out_last, b_out_data}), 32'h3EF);
    @(negedge clk);
    check_eq("b_idle", 32'({b_out_valid, b_busy}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
Downstream stage of the 32-bit multi-function ALU. It captures the full ALU result and its four status flags on a valid/ready capture handshake. It then streams the captured frame out one byte at a time on an 8-bit valid/ready byte stream, so the whole result is visible through the 8-bit pad interface, not just the low 16 bits. A one-entry pending buffer lets a second result be captured while the current frame is still being streamed.

Parameters:
DATA_W, 32, result width in bits; must be a multiple of 8 and ≤ 64.
MSB_FIRST, 0, 0 = result bytes sent least-significant first; 1 = most-significant first.
INCLUDE_HDR, 1, 1 = each frame starts with a header byte; 0 = result bytes only.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cap_valid  input  1  capture request
cap_ready  output  1  capture accepted when cap_valid && cap_ready
cap_result  input  DATA_W  ALU result
cap_flags  input  4  {zero, carry, overflow, negative}
out_valid  output  1  byte available
out_ready  input  1  consumer accepts byte
out_data  output  8  frame byte
out_last  output  1  marks the final byte of the frame
busy  output  1  high when a frame is active or the pending buffer is full
seq  output  4  sequence number of the frame currently on out_data

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - Reset values: out_valid=0, out_data=0, out_last=0, busy=0, seq=0, cap_ready=1.
  - State=IDLE, pending buffer empty, sequence counter=0.
- Frame format:
  - Header byte (only if INCLUDE_HDR=1): {flags[3:0], seq[3:0]}.
  - Followed by NB=DATA_W/8 result bytes in the order set by MSB_FIRST.
  - Frame length = NB + INCLUDE_HDR.
  - out_last is high only on the final byte.
- Sequence counter:
  - Each accepted capture is tagged with the counter value; the counter then increments.
  - 4-bit counter, wraps 15→0.
  - Output seq shows the tag of the active frame.
- Capture handshake:
  - cap_ready = !pending_full. This is combinational from state only, never from cap_valid.
- States:
  - IDLE: no active frame.
  - HDR: presenting the header byte.
  - DATA: presenting result bytes; a byte index counts 0..NB-1.
- Acceptance in IDLE: the capture loads the active registers. Next cycle: out_valid=1, first byte presented (HDR, or DATA index 0 if INCLUDE_HDR=0). Latency from capture to out_valid is 1 cycle.
- Acceptance while a frame is active: the capture loads the pending buffer; pending_full=1, so cap_ready drops next cycle.
- Byte transfer occurs on out_valid && out_ready.
  - While out_valid && !out_ready: out_data, out_last and seq hold stable.
  - out_valid never deasserts before the transfer.
- Transfer of the last byte:
  - If pending is full: the pending frame moves to active and pending clears. The next cycle presents its first byte, with no bubble.
  - Else, if a capture is accepted in the same cycle: it goes straight to active, with no bubble.
  - Else: go to IDLE, out_valid=0 next cycle.
- A capture arriving while pending is full is not accepted (cap_ready=0); the producer must hold it. No data is ever dropped or overwritten.
- busy = (state != IDLE) || pending_full.
- Reset asserted mid-frame: the frame and pending data are discarded immediately, outputs return to reset values, and the sequence counter returns to 0.
- out_data and out_last are registered outputs; out_data = 0 whenever out_valid = 0.

Test Plan:
- Single frame: defaults, out_ready=1; capture cap_result=0xDEADBEEF, flags=4'b1000. Required: bytes 0x80, 0xEF, 0xBE, 0xAD, 0xDE on 5 consecutive cycles starting 1 cycle after capture; out_last only on 0xDE; then IDLE, busy=0.
- Back-pressure: same frame, out_ready=0 for 3 cycles while 0xBE is presented. Required: out_data holds 0xBE, out_last=0 and out_valid=1 throughout; the frame completes normally after release.
- Back-to-back: captures 0x11223344 then 0x55667788 on consecutive cycles, third capture held. Required: second capture goes to pending and cap_ready=0; headers carry seq 0 then 1 with no idle cycle between frames; third capture is accepted only after the first frame's last byte.
- Same-cycle last byte and capture, pending empty: the new frame header follows the previous 0xDE byte on the very next cycle; seq increments by 1.
- Sequence wrap: 17 single frames. Required: headers show seq 0..15 then 0; flags nibble matches each capture.
- Parameter variant and reset: MSB_FIRST=1, INCLUDE_HDR=0, capture 0xDEADBEEF. Required: bytes DE, AD, BE, EF. Assert rst_n mid-frame after byte AD: out_valid=0, cap_ready=1, seq=0 immediately; the next capture restarts at byte DE.
